// File: rtl/kp_linebuffer_win.sv
// kp_linebuffer_win: single-line circular pixel store returning a TAPS-wide window centred on the read column
// Ports: i_clk/i_rst clock and sync active-high reset; i_wr/i_wdata pixel write;
// i_rd window read; o_rdata window (MSB slice = c-R); o_valid read result strobe;
// o_count unread pixels; o_empty/o_full flow control; o_wr_drop/o_rd_drop refused-request pulses.
module kp_linebuffer_win #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINE_LENGTH = 640,
    parameter int TAPS        = 3,
    parameter int BORDER_MODE = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_wr,
    input  logic [DATA_WIDTH-1:0]                i_wdata,
    input  logic                                 i_rd,
    output logic [TAPS*DATA_WIDTH-1:0]           o_rdata,
    output logic                                 o_valid,
    output logic [$clog2(LINE_LENGTH+1)-1:0]     o_count,
    output logic                                 o_empty,
    output logic                                 o_full,
    output logic                                 o_wr_drop,
    output logic                                 o_rd_drop
);
    localparam int R  = (TAPS - 1) / 2;
    localparam int CW = $clog2(LINE_LENGTH + 1);
    localparam int PW = LINE_LENGTH > 1 ? $clog2(LINE_LENGTH) : 1;

    logic [DATA_WIDTH-1:0]      mem [LINE_LENGTH];
    logic [PW-1:0]              wptr, rptr;
    logic [TAPS*DATA_WIDTH-1:0] win;
    logic                       wr_ok, rd_ok;
    int                         need, col;

    // need: how many unread pixels must exist so the rightmost in-line tap is written
    always_comb begin
        need  = (LINE_LENGTH - 1 - int'(rptr)) < R ? LINE_LENGTH - 1 - int'(rptr) : R;
        wr_ok = i_wr && int'(o_count) < LINE_LENGTH - R;
        rd_ok = i_rd && int'(o_count) > need;
        win   = '0;
        col   = 0;
        for (int j = 0; j < TAPS; j++) begin
            col = int'(rptr) + R - j;
            win[j*DATA_WIDTH +: DATA_WIDTH] =
                col < 0                ? ((BORDER_MODE != 0) ? mem[PW'(0)] : '0) :
                col > LINE_LENGTH - 1  ? ((BORDER_MODE != 0) ? mem[PW'(LINE_LENGTH-1)] : '0) :
                                         mem[PW'(col)];
        end
    end

    assign o_empty = !(int'(o_count) > need);
    assign o_full  = int'(o_count) >= LINE_LENGTH - R;

    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_rst)
            mem[wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            o_count   <= '0;
            o_rdata   <= '0;
            o_valid   <= 1'b0;
            o_wr_drop <= 1'b0;
            o_rd_drop <= 1'b0;
        end else begin
            wptr      <= wr_ok ? (wptr == PW'(LINE_LENGTH-1) ? '0 : wptr + PW'(1)) : wptr;
            rptr      <= rd_ok ? (rptr == PW'(LINE_LENGTH-1) ? '0 : rptr + PW'(1)) : rptr;
            o_count   <= o_count + CW'(wr_ok) - CW'(rd_ok);
            o_rdata   <= rd_ok ? win : o_rdata;
            o_valid   <= rd_ok;
            o_wr_drop <= i_wr && !wr_ok;
            o_rd_drop <= i_rd && !rd_ok;
        end
    end
endmodule

// File: tb/tb_kp_linebuffer_win.sv
// tb_kp_linebuffer_win: directed and randomized checks of kp_linebuffer_win in both border modes
module tb_kp_linebuffer_win;
    localparam int L = 8;
    localparam int R = 1;

    logic        clk = 0;
    logic        rst = 0, wr = 0, rd = 0;
    logic [7:0]  wdata = 0;
    logic [23:0] rd1, rd0;
    logic        v1, v0, emp1, emp0, full1, full0, wd1, wd0, rdd1, rdd0;
    logic [3:0]  cnt1, cnt0;

    int vectors = 0, miscompares = 0;

    logic [7:0]  mm [L];
    int          m_w, m_r, m_cnt;
    logic [23:0] e_rd1, e_rd0;
    bit          e_v, e_wd, e_rdd;

    always #5 clk = ~clk;

    kp_linebuffer_win #(.DATA_WIDTH(8), .LINE_LENGTH(L), .TAPS(3), .BORDER_MODE(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
        .o_rdata(rd1), .o_valid(v1), .o_count(cnt1), .o_empty(emp1), .o_full(full1),
        .o_wr_drop(wd1), .o_rd_drop(rdd1));

    kp_linebuffer_win #(.DATA_WIDTH(8), .LINE_LENGTH(L), .TAPS(3), .BORDER_MODE(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
        .o_rdata(rd0), .o_valid(v0), .o_count(cnt0), .o_empty(emp0), .o_full(full0),
        .o_wr_drop(wd0), .o_rd_drop(rdd0));

    function automatic logic [23:0] window(input bit bm, input int c);
        logic [23:0] r;
        logic [7:0]  v;
        int          cc;
        r = 0;
        for (int k = -R; k <= R; k++) begin
            cc = c + k;
            if (cc < 0) v = bm ? mm[0] : 8'h00;
            else if (cc > L - 1) v = bm ? mm[L-1] : 8'h00;
            else v = mm[cc];
            r = {r[15:0], v};
        end
        return r;
    endfunction

    function automatic bit exp_empty();
        int need;
        need = (L - 1 - m_r < R) ? L - 1 - m_r : R;
        return !(m_cnt > need);
    endfunction

    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit q);
        int need;
        bit wa, ra;
        rst = r; wr = w; wdata = d; rd = q;
        @(posedge clk); #1;
        rst = 0; wr = 0; rd = 0;
        if (r) begin
            m_w = 0; m_r = 0; m_cnt = 0;
            e_rd1 = 0; e_rd0 = 0; e_v = 0; e_wd = 0; e_rdd = 0;
        end else begin
            need  = (L - 1 - m_r < R) ? L - 1 - m_r : R;
            wa    = w && m_cnt < L - R;
            ra    = q && m_cnt > need;
            e_v   = ra;
            e_wd  = w && !wa;
            e_rdd = q && !ra;
            if (ra) begin
                e_rd1 = window(1, m_r);
                e_rd0 = window(0, m_r);
                m_r   = (m_r + 1) % L;
            end
            if (wa) begin
                mm[m_w] = d;
                m_w     = (m_w + 1) % L;
            end
            m_cnt = m_cnt + int'(wa) - int'(ra);
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        vectors++; if (cnt1 !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", cnt1); end
        vectors++; if (emp1 !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", emp1); end
        vectors++; if (full1 !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full1); end
        vectors++; if (v1 !== 1'b0 || v0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b/%b want 0/0", v1, v0); end
        vectors++; if (rd1 !== 24'h0 || rd0 !== 24'h0) begin miscompares++; $display("FAIL reset_rdata got %h/%h want 0/0", rd1, rd0); end
        vectors++; if (wd1 !== 1'b0 || rdd1 !== 1'b0) begin miscompares++; $display("FAIL reset_drops got %b%b want 00", wd1, rdd1); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h10 + i), 0);
        vectors++; if (cnt1 !== 4'd7) begin miscompares++; $display("FAIL fill_count got %0d want 7", cnt1); end
        vectors++; if (full1 !== 1'b1 || emp1 !== 1'b0) begin miscompares++; $display("FAIL fill_flags got full=%b empty=%b want 1/0", full1, emp1); end
        step(0, 1, 8'h17, 0);
        vectors++; if (wd1 !== 1'b1) begin miscompares++; $display("FAIL wr_drop got %b want 1", wd1); end
        vectors++; if (cnt1 !== 4'd7) begin miscompares++; $display("FAIL drop_count got %0d want 7", cnt1); end
        step(0, 0, 0, 0);
        vectors++; if (wd1 !== 1'b0) begin miscompares++; $display("FAIL wr_drop_pulse got %b want 0", wd1); end
    endtask

    task automatic test_read_window();
        step(0, 0, 0, 1);
        vectors++; if (v1 !== 1'b1 || v0 !== 1'b1) begin miscompares++; $display("FAIL rd_valid got %b/%b want 1/1", v1, v0); end
        vectors++; if (rd1 !== 24'h101011) begin miscompares++; $display("FAIL win_c0_rep got %h want 101011", rd1); end
        vectors++; if (rd0 !== 24'h001011) begin miscompares++; $display("FAIL win_c0_zero got %h want 001011", rd0); end
        step(0, 0, 0, 1);
        vectors++; if (rd1 !== 24'h101112 || rd0 !== 24'h101112) begin miscompares++; $display("FAIL win_c1 got %h/%h want 101112", rd1, rd0); end
        step(0, 0, 0, 0);
        vectors++; if (v1 !== 1'b0) begin miscompares++; $display("FAIL valid_pulse got %b want 0", v1); end
        vectors++; if (rd1 !== 24'h101112) begin miscompares++; $display("FAIL rdata_hold got %h want 101112", rd1); end
    endtask

    task automatic test_rd_underflow();
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h10 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        vectors++; if (cnt1 !== 4'd1 || emp1 !== 1'b1) begin miscompares++; $display("FAIL c3_state got count=%0d empty=%b want 1/1", cnt1, emp1); end
        step(0, 0, 0, 1);
        vectors++; if (rdd1 !== 1'b1 || v1 !== 1'b0) begin miscompares++; $display("FAIL rd_drop got drop=%b valid=%b want 1/0", rdd1, v1); end
        vectors++; if (cnt1 !== 4'd1) begin miscompares++; $display("FAIL rd_drop_count got %0d want 1", cnt1); end
        step(0, 0, 0, 0);
        vectors++; if (rdd1 !== 1'b0) begin miscompares++; $display("FAIL rd_drop_pulse got %b want 0", rdd1); end
        for (int i = 4; i < 8; i++) step(0, 1, 8'(8'h10 + i), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        vectors++; if (cnt1 !== 4'd1 || emp1 !== 1'b0) begin miscompares++; $display("FAIL c7_state got count=%0d empty=%b want 1/0", cnt1, emp1); end
        step(0, 0, 0, 1);
        vectors++; if (v1 !== 1'b1) begin miscompares++; $display("FAIL c7_valid got %b want 1", v1); end
        vectors++; if (rd1 !== 24'h161717) begin miscompares++; $display("FAIL win_c7_rep got %h want 161717", rd1); end
        vectors++; if (rd0 !== 24'h161700) begin miscompares++; $display("FAIL win_c7_zero got %h want 161700", rd0); end
        vectors++; if (cnt1 !== 4'd0 || emp1 !== 1'b1) begin miscompares++; $display("FAIL c7_after got count=%0d empty=%b want 0/1", cnt1, emp1); end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 8'($urandom), 1);
            vectors++; if (cnt1 !== 4'd3 || v1 !== 1'b1) begin miscompares++; $display("FAIL b2b_state[%0d] got count=%0d valid=%b want 3/1", i, cnt1, v1); end
            vectors++; if (rd1 !== e_rd1 || rd0 !== e_rd0) begin miscompares++; $display("FAIL b2b_win[%0d] got %h/%h want %h/%h", i, rd1, rd0, e_rd1, e_rd0); end
        end
        step(1, 1, 8'($urandom), 1);
        vectors++; if (cnt1 !== 4'd0 || emp1 !== 1'b1 || full1 !== 1'b0) begin miscompares++; $display("FAIL midrst_flags got count=%0d empty=%b full=%b want 0/1/0", cnt1, emp1, full1); end
        vectors++; if (v1 !== 1'b0 || rd1 !== 24'h0 || rd0 !== 24'h0) begin miscompares++; $display("FAIL midrst_out got valid=%b rdata=%h/%h want 0/0/0", v1, rd1, rd0); end
        vectors++; if (wd1 !== 1'b0 || rdd1 !== 1'b0) begin miscompares++; $display("FAIL midrst_drops got %b%b want 00", wd1, rdd1); end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1);
            vectors++; if (cnt1 !== 4'(m_cnt) || cnt0 !== 4'(m_cnt)) begin miscompares++; $display("FAIL rnd_count[%0d] got %0d/%0d want %0d", i, cnt1, cnt0, m_cnt); end
            vectors++; if (emp1 !== exp_empty() || full1 !== (m_cnt >= L - R)) begin miscompares++; $display("FAIL rnd_flags[%0d] got empty=%b full=%b want %b/%b", i, emp1, full1, exp_empty(), m_cnt >= L - R); end
            vectors++; if (v1 !== e_v || v0 !== e_v) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b/%b want %b", i, v1, v0, e_v); end
            vectors++; if (rd1 !== e_rd1 || rd0 !== e_rd0) begin miscompares++; $display("FAIL rnd_win[%0d] got %h/%h want %h/%h", i, rd1, rd0, e_rd1, e_rd0); end
            vectors++; if (wd1 !== e_wd || rdd1 !== e_rdd || wd0 !== e_wd || rdd0 !== e_rdd) begin miscompares++; $display("FAIL rnd_drops[%0d] got %b%b want %b%b", i, wd1, rdd1, e_wd, e_rdd); end
            vectors++; if (emp0 !== emp1 || full0 !== full1) begin miscompares++; $display("FAIL rnd_flags_bm0[%0d] got %b%b want %b%b", i, emp0, full0, emp1, full1); end
        end
    endtask

    initial begin
        for (int i = 0; i < L; i++) mm[i] = 0;
        m_w = 0; m_r = 0; m_cnt = 0;
        e_rd1 = 0; e_rd0 = 0; e_v = 0; e_wd = 0; e_rdd = 0;
        @(posedge clk); #1;
        test_reset();
        test_overflow();
        test_read_window();
        test_rd_underflow();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
